// File: rtl/enc_hl.sv
// enc_hl: source-side HL packet encoder. Builds the HL head flit from a
// unicast/multicast request and streams head/body/tail flits to the local
// router under credit-based flow control.
module enc_hl #(
  parameter int unsigned MY_XPOS   = 0,
  parameter int unsigned MY_YPOS   = 0,
  parameter int unsigned BUF_DEPTH = 4,
  parameter int unsigned LEN_W     = 4,
  parameter int unsigned FLIT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_um_type,
  input  logic [4:0]        req_uni_dst,
  input  logic [15:0]       req_dst_map,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              pl_valid,
  output logic              pl_ready,
  input  logic [FLIT_W-3:0] pl_data,
  output logic [FLIT_W-1:0] flit_out,
  output logic              flit_valid,
  input  logic              credit_in,
  output logic              err_drop,
  output logic              busy
);

  localparam int unsigned CRD_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CRD_W-1:0] CRD_MAX  = CRD_W'(BUF_DEPTH);
  localparam logic [3:0]       OWN_NODE = 4'(MY_XPOS * 4 + MY_YPOS);
  localparam logic [1:0]       X2       = 2'(MY_XPOS);
  localparam logic [1:0]       Y2       = 2'(MY_YPOS);
  localparam logic [1:0]       SRC_POS  = {X2[1], Y2[1]};

  localparam logic [1:0] T_SINGLE = 2'b00;
  localparam logic [1:0] T_HEAD   = 2'b01;
  localparam logic [1:0] T_BODY   = 2'b10;
  localparam logic [1:0] T_TAIL   = 2'b11;

  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

  state_t           state, state_nxt;
  logic [CRD_W-1:0] credit, credit_nxt;
  logic             hd_um;
  logic [4:0]       hd_uni;
  logic [19:0]      hd_mult;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] remaining;

  logic [15:0] map_c;
  logic [3:0]  qmask_c;
  logic        drop_c;
  logic        accept_c;
  logic        send_head_c;
  logic        send_body_c;
  logic        send_c;
  logic [31:0] head_c;
  logic [1:0]  body_type_c;

  assign req_ready = (state == IDLE);

  // Destination encoding of the incoming request and its drop decision
  always_comb begin
    map_c           = req_dst_map;
    map_c[OWN_NODE] = 1'b0;
    qmask_c         = '0;
    for (int n = 0; n < 16; n++) begin
      if (map_c[n]) qmask_c[{n[3], n[1]}] = 1'b1;
    end
    if (req_um_type) drop_c = (map_c == '0);
    else             drop_c = req_uni_dst[4] || (req_uni_dst[3:0] == OWN_NODE);
    accept_c = (state == IDLE) && req_valid && !drop_c;
  end

  // Send decisions, next state and credit bookkeeping
  always_comb begin
    send_head_c = (state == HEAD) && (credit != '0);
    send_body_c = (state == BODY) && pl_valid && pl_ready;
    send_c      = send_head_c || send_body_c;
    head_c      = {(len_q == '0) ? T_SINGLE : T_HEAD, hd_um, SRC_POS, hd_uni, hd_mult, 2'b00};
    body_type_c = (remaining == LEN_W'(1)) ? T_TAIL : T_BODY;

    state_nxt = state;
    case (state)
      IDLE:    if (accept_c) state_nxt = HEAD;
      HEAD:    if (send_head_c) state_nxt = (len_q == '0) ? IDLE : BODY;
      BODY:    if (send_body_c && remaining == LEN_W'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Simultaneous send and return cancel out; returns saturate at full
    credit_nxt = credit;
    if (send_c && !credit_in)
      credit_nxt = credit - CRD_W'(1);
    else if (!send_c && credit_in && credit != CRD_MAX)
      credit_nxt = credit + CRD_W'(1);
  end

  // State, credit counter, latched header and registered flit outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      credit     <= CRD_MAX;
      hd_um      <= 1'b0;
      hd_uni     <= '0;
      hd_mult    <= '0;
      len_q      <= '0;
      remaining  <= '0;
      flit_out   <= '0;
      flit_valid <= 1'b0;
      err_drop   <= 1'b0;
      pl_ready   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      credit     <= credit_nxt;
      busy       <= (state_nxt != IDLE);
      pl_ready   <= (state_nxt == BODY) && (credit_nxt != '0);
      flit_valid <= send_c;
      err_drop   <= (state == IDLE) && req_valid && drop_c;
      if (accept_c) begin
        hd_um   <= req_um_type;
        hd_uni  <= req_uni_dst;
        hd_mult <= req_um_type ? {qmask_c, map_c} : 20'd0;
        len_q   <= req_len;
      end
      if (send_head_c) begin
        flit_out  <= FLIT_W'(head_c);
        remaining <= len_q;
      end
      if (send_body_c) begin
        flit_out  <= {body_type_c, pl_data};
        remaining <= remaining - LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_enc_hl.sv
// tb_enc_hl: directed and randomized checks of enc_hl against a
// transaction-level model of the encoder and a credit-tracking router.
module tb_enc_hl;

  localparam int unsigned MX = 2;
  localparam int unsigned MY = 1;
  localparam int unsigned BD = 2;
  localparam int unsigned LW = 4;
  localparam int unsigned FW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_um_type = 1'b0;
  logic [4:0]    req_uni_dst = '0;
  logic [15:0]   req_dst_map = '0;
  logic [LW-1:0] req_len = '0;
  logic          pl_valid = 1'b0;
  logic          pl_ready;
  logic [FW-3:0] pl_data = '0;
  logic [FW-1:0] flit_out;
  logic          flit_valid;
  logic          credit_in = 1'b0;
  logic          err_drop;
  logic          busy;

  enc_hl #(.MY_XPOS(MX), .MY_YPOS(MY), .BUF_DEPTH(BD), .LEN_W(LW), .FLIT_W(FW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_um_type(req_um_type),
    .req_uni_dst(req_uni_dst), .req_dst_map(req_dst_map), .req_len(req_len),
    .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
    .flit_out(flit_out), .flit_valid(flit_valid), .credit_in(credit_in),
    .err_drop(err_drop), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state
  int          mcred = BD;
  bit          head_pend = 1'b0;
  int          body_left = 0;
  logic [31:0] expq[$];
  logic [29:0] payq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_head(input bit um, input logic [4:0] uni,
                                             input logic [15:0] dst, input int len);
    int own, map, qm, src, typ;
    longint mult, h;
    own = MX * 4 + MY;
    map = int'(dst) & ~(1 << own);
    qm  = 0;
    for (int n = 0; n < 16; n++)
      if ((map >> n) & 1) qm = qm | (1 << ((n / 8) * 2 + (n / 2) % 2));
    mult = um ? ((longint'(qm) << 16) | longint'(map)) : 0;
    src  = (MX / 2) * 2 + (MY / 2);
    typ  = (len == 0) ? 0 : 1;
    h = (longint'(typ) << 30) | (longint'(um) << 29) | (longint'(src) << 27) |
        (longint'(uni) << 22) | (mult << 2);
    return 32'(h);
  endfunction

  // One clock: drive payload/credit, predict the send, check outputs after the edge
  task automatic cycle(input bit pv, input bit ci);
    int pre;
    bit exp_send, exp_pr;
    logic [31:0] e;
    pre       = mcred;
    pl_valid  = pv;
    pl_data   = (payq.size() > 0) ? payq[0] : 30'($urandom);
    credit_in = ci;
    exp_pr    = !head_pend && body_left > 0 && pre > 0;
    chk("pl_ready", 32'(pl_ready), 32'(exp_pr));
    if (head_pend) exp_send = pre > 0;
    else           exp_send = body_left > 0 && pv && pre > 0;
    @(posedge clk);
    #1;
    chk("flit_valid", 32'(flit_valid), 32'(exp_send));
    if (exp_send) begin
      e = expq.pop_front();
      chk("flit_out", flit_out, e);
      if (head_pend) head_pend = 1'b0;
      else begin
        body_left--;
        void'(payq.pop_front());
      end
    end
    if (exp_send && !ci)                 mcred = pre - 1;
    else if (!exp_send && ci && pre < BD) mcred = pre + 1;
    else                                  mcred = pre;
    pl_valid  = 1'b0;
    credit_in = 1'b0;
    chk("busy", 32'(busy), 32'(head_pend || body_left > 0));
    chk("req_ready", 32'(req_ready), 32'(!(head_pend || body_left > 0)));
    chk("err_drop_idle", 32'(err_drop), 32'd0);
  endtask

  task automatic send_req(input bit um, input logic [4:0] uni, input logic [15:0] dst, input int len);
    bit drop;
    int own, map;
    logic [29:0] w;
    own  = MX * 4 + MY;
    map  = int'(dst) & ~(1 << own);
    drop = um ? (map == 0) : (uni[4] || int'(uni[3:0]) == own);
    chk("req_ready_pre", 32'(req_ready), 32'd1);
    req_valid   = 1'b1;
    req_um_type = um;
    req_uni_dst = uni;
    req_dst_map = dst;
    req_len     = LW'(len);
    pl_valid    = 1'b0;
    credit_in   = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("err_drop", 32'(err_drop), 32'(drop));
    chk("busy_accept", 32'(busy), 32'(!drop));
    chk("flit_valid_accept", 32'(flit_valid), 32'd0);
    if (drop) cycle(1'b0, 1'b0);
    else begin
      head_pend = 1'b1;
      body_left = len;
      expq.push_back(model_head(um, uni, dst, len));
      for (int k = 0; k < len; k++) begin
        w = 30'($urandom);
        payq.push_back(w);
        expq.push_back({(k == len - 1) ? 2'b11 : 2'b10, w});
      end
    end
  endtask

  // pv_mode: 0 always, 1 random, 2 alternating; ci_mode: 0 none, 1 always, 2 random
  task automatic run_pkt(input int pv_mode, input int ci_mode);
    int guard;
    bit pv, ci;
    guard = 0;
    while ((head_pend || body_left > 0) && guard < 300) begin
      case (pv_mode)
        0:       pv = 1'b1;
        1:       pv = 1'($urandom);
        default: pv = (guard % 2 == 1);
      endcase
      case (ci_mode)
        0:       ci = 1'b0;
        1:       ci = (mcred < BD);
        default: ci = (mcred < BD) && 1'($urandom);
      endcase
      cycle(pv, ci);
      guard++;
    end
    chk("pkt_done", 32'(busy), 32'd0);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (mcred < BD && guard < 20) begin
      cycle(1'b0, 1'b1);
      guard++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    pl_valid = 1'b0;
    credit_in = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mcred = BD;
    head_pend = 1'b0;
    body_left = 0;
    expq.delete();
    payq.delete();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flit_valid", 32'(flit_valid), 32'd0);
    chk("rst_flit_out", flit_out, 32'd0);
    chk("rst_pl_ready", 32'(pl_ready), 32'd0);
    chk("rst_err_drop", 32'(err_drop), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    bit um;
    logic [15:0] dst;
    logic [4:0] uni;
    int len, guard;

    // Reset state
    @(posedge clk);
    do_reset();

    // Multicast single-flit packet: head type 00, qmask B over map 0428
    send_req(1'b1, 5'd0, 16'h0428, 0);
    chk("mc_head_model", expq[0], 32'h20000000 | (32'h2 << 27) | (32'hB0428 << 2));
    run_pkt(0, 1);
    drain();

    // Multicast to self only is dropped
    send_req(1'b1, 5'd0, 16'h0200, 2);
    // Unicast to own node and to an out-of-range node are dropped
    send_req(1'b0, 5'd9, 16'h0000, 1);
    send_req(1'b0, 5'd19, 16'h0000, 1);

    // Unicast len 3 with steady payload and credit return: 01,10,10,11 back to back
    send_req(1'b0, 5'd7, 16'hFFFF, 3);
    run_pkt(0, 1);
    drain();

    // Credit saturation at full, then stall without returns
    cycle(1'b0, 1'b1);
    send_req(1'b0, 5'd3, 16'h0000, 3);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    chk("stall_done", 32'(busy), 32'd0);
    drain();

    // Payload gaps
    send_req(1'b1, 5'd0, 16'h8001, 4);
    run_pkt(2, 1);
    drain();

    // Longest packet
    send_req(1'b0, 5'd15, 16'h0000, 15);
    run_pkt(1, 2);
    drain();

    // Reset after the second body flit of a len 5 packet
    send_req(1'b0, 5'd2, 16'h0000, 5);
    guard = 0;
    while (body_left > 3 && guard < 50) begin
      cycle(1'b1, mcred < BD);
      guard++;
    end
    do_reset();
    // Two flits with no returns prove the counter is back at full
    send_req(1'b0, 5'd5, 16'h0000, 1);
    run_pkt(0, 0);
    drain();

    // Randomized packets
    for (int p = 0; p < 30; p++) begin
      um  = 1'($urandom);
      dst = 16'($urandom);
      if (p % 7 == 3) dst = 16'h0200;
      uni = ($urandom % 4 == 0) ? 5'($urandom) : {1'b0, 4'($urandom)};
      len = int'($urandom % 6);
      send_req(um, uni, dst, len);
      run_pkt(int'($urandom % 3), 1 + int'($urandom % 2));
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
